// File: rtl/bg_theme_scheduler.sv
// Background theme scheduler: round-robin arbitration of two theme-change requesters,
// frame-boundary commit of the granted theme, and a timed full-screen inversion flash.
module bg_theme_scheduler #(
    parameter int         FLASH_FRAMES = 30,
    parameter logic [1:0] INIT_THEME   = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       reqA_valid,
    input  logic [1:0] reqA_theme,
    output logic       reqA_ready,
    input  logic       reqB_valid,
    input  logic [1:0] reqB_theme,
    output logic       reqB_ready,
    input  logic       flash_req,
    output logic [1:0] theme_idx,
    output logic [2:0] base_R,
    output logic [2:0] base_G,
    output logic [1:0] base_B,
    output logic [7:0] border_RGB,
    output logic       flash_active,
    output logic       pending
);

    typedef enum logic {
        IDLE,
        HOLD
    } chg_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ARMED,
        F_ON
    } flash_state_t;

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    function automatic logic [7:0] theme_lut(input logic [1:0] t);
        case (t)
            2'd0:    theme_lut = 8'b010_110_00;
            2'd1:    theme_lut = 8'b000_000_11;
            2'd2:    theme_lut = 8'b111_011_00;
            default: theme_lut = 8'b011_011_01;
        endcase
    endfunction

    function automatic logic [7:0] border_lut(input logic [1:0] t);
        border_lut = (t == 2'd1) ? 8'hFF : 8'hFC;
    endfunction

    chg_state_t   chg_state, chg_next;
    flash_state_t flash_state, flash_next;
    logic         rr_b_next;
    logic [1:0]   pend_theme;
    logic [1:0]   theme_next;
    logic         grant_a, grant_b;
    logic [7:0]   cnt_q, cnt_next;
    logic         reload_q, reload_next;
    logic         flash_on_next;
    logic [7:0]   colour_next;

    // Arbiter: a lone requester always wins; on contention rr_b_next picks the side.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && chg_state == IDLE) begin
            if (reqA_valid && reqB_valid) begin
                grant_a = !rr_b_next;
                grant_b = rr_b_next;
            end else begin
                grant_a = reqA_valid;
                grant_b = reqB_valid;
            end
        end
    end

    assign reqA_ready = grant_a;
    assign reqB_ready = grant_b;

    always_comb begin
        chg_next   = chg_state;
        theme_next = theme_idx;
        case (chg_state)
            IDLE: if (grant_a || grant_b) chg_next = HOLD;
            HOLD: begin
                if (startOfFrame) begin
                    chg_next   = IDLE;
                    theme_next = pend_theme;
                end
            end
            default: chg_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chg_state  <= IDLE;
            rr_b_next  <= 1'b0;
            pend_theme <= INIT_THEME;
        end else begin
            chg_state <= chg_next;
            if (grant_a) begin
                pend_theme <= reqA_theme;
                rr_b_next  <= 1'b1;
            end else if (grant_b) begin
                pend_theme <= reqB_theme;
                rr_b_next  <= 1'b0;
            end
        end
    end

    // A flash request seen while on is remembered and turned into a reload at the next frame.
    always_comb begin
        flash_next  = flash_state;
        cnt_next    = cnt_q;
        reload_next = reload_q;
        case (flash_state)
            F_IDLE: if (flash_req) flash_next = F_ARMED;
            F_ARMED: begin
                if (startOfFrame) begin
                    cnt_next   = FLASH_LOAD;
                    flash_next = F_ON;
                end
            end
            F_ON: begin
                if (startOfFrame) begin
                    reload_next = 1'b0;
                    if (reload_q || flash_req) begin
                        cnt_next = FLASH_LOAD;
                    end else if (cnt_q <= 8'd1) begin
                        cnt_next   = 8'd0;
                        flash_next = F_IDLE;
                    end else begin
                        cnt_next = cnt_q - 8'd1;
                    end
                end else if (flash_req) begin
                    reload_next = 1'b1;
                end
            end
            default: flash_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_state <= F_IDLE;
            cnt_q       <= 8'd0;
            reload_q    <= 1'b0;
        end else begin
            flash_state <= flash_next;
            cnt_q       <= cnt_next;
            reload_q    <= reload_next;
        end
    end

    assign flash_on_next = (flash_next == F_ON);
    assign colour_next   = theme_lut(theme_next) ^ (flash_on_next ? 8'hFF : 8'h00);

    // Colours are registered from the next-state values so they move on the same edge as theme_idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            theme_idx    <= INIT_THEME;
            {base_R, base_G, base_B} <= theme_lut(INIT_THEME);
            border_RGB   <= border_lut(INIT_THEME);
            flash_active <= 1'b0;
            pending      <= 1'b0;
        end else begin
            theme_idx    <= theme_next;
            {base_R, base_G, base_B} <= colour_next;
            border_RGB   <= border_lut(theme_next);
            flash_active <= flash_on_next;
            pending      <= (chg_next == HOLD);
        end
    end

endmodule

// File: tb/tb_bg_theme_scheduler.sv
// Self-checking bench for bg_theme_scheduler: a per-cycle reference model plus
// hand-computed checkpoints for arbitration, frame-synchronous commit and the flash.
module tb_bg_theme_scheduler;

    localparam int         FF   = 3;
    localparam logic [1:0] INIT = 2'd0;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       reqA_valid;
    logic [1:0] reqA_theme;
    logic       reqA_ready;
    logic       reqB_valid;
    logic [1:0] reqB_theme;
    logic       reqB_ready;
    logic       flash_req;
    logic [1:0] theme_idx;
    logic [2:0] base_R;
    logic [2:0] base_G;
    logic [1:0] base_B;
    logic [7:0] border_RGB;
    logic       flash_active;
    logic       pending;

    int total = 0;
    int bad   = 0;

    bg_theme_scheduler #(.FLASH_FRAMES(FF), .INIT_THEME(INIT)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .reqA_valid(reqA_valid), .reqA_theme(reqA_theme), .reqA_ready(reqA_ready),
        .reqB_valid(reqB_valid), .reqB_theme(reqB_theme), .reqB_ready(reqB_ready),
        .flash_req(flash_req), .theme_idx(theme_idx),
        .base_R(base_R), .base_G(base_G), .base_B(base_B),
        .border_RGB(border_RGB), .flash_active(flash_active), .pending(pending)
    );

    always #5 clk = ~clk;

    logic [7:0] lut [4] = '{8'b010_110_00, 8'b000_000_11, 8'b111_011_00, 8'b011_011_01};

    // Reference model: committed theme, held change, who won last, and frames of flash left.
    bit         m_valid = 1'b0;
    logic [1:0] m_theme;
    bit         m_pending;
    logic [1:0] m_pend_theme;
    bit         m_last_was_b;
    bit         m_armed;
    int         m_left;
    bit         m_reload;

    function automatic logic [1:0] expReady();
        logic [1:0] r;
        r = 2'b00;
        if (!reset && !m_pending) begin
            if (reqA_valid && reqB_valid) r = m_last_was_b ? 2'b10 : 2'b01;
            else r = {reqA_valid, reqB_valid};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        bit pre_armed, pre_on;
        if (reset) begin
            m_valid = 1'b1; m_theme = INIT; m_pending = 1'b0; m_pend_theme = INIT;
            m_last_was_b = 1'b1; m_armed = 1'b0; m_left = 0; m_reload = 1'b0;
        end else if (m_valid) begin
            g = expReady();
            if (m_pending && startOfFrame) begin
                m_theme = m_pend_theme; m_pending = 1'b0;
            end else if (g == 2'b10) begin
                m_pend_theme = reqA_theme; m_pending = 1'b1; m_last_was_b = 1'b0;
            end else if (g == 2'b01) begin
                m_pend_theme = reqB_theme; m_pending = 1'b1; m_last_was_b = 1'b1;
            end
            pre_armed = m_armed;
            pre_on    = (m_left > 0);
            if (pre_on && flash_req) m_reload = 1'b1;
            if (startOfFrame) begin
                if (pre_armed) begin
                    m_left = FF; m_armed = 1'b0;
                end else if (pre_on) begin
                    m_left = m_reload ? FF : m_left - 1;
                    m_reload = 1'b0;
                end
            end
            if (!pre_armed && !pre_on && flash_req) m_armed = 1'b1;
        end
    end

    // Compare every cycle, mid-period, once the model has seen a reset edge.
    always @(negedge clk) begin
        logic [7:0] eb;
        logic [1:0] er;
        if (m_valid) begin
            eb = lut[m_theme] ^ ((m_left > 0) ? 8'hFF : 8'h00);
            er = expReady();
            total++;
            if (theme_idx !== m_theme || {base_R, base_G, base_B} !== eb ||
                border_RGB !== ((m_theme == 2'd1) ? 8'hFF : 8'hFC) ||
                flash_active !== (m_left > 0) || pending !== m_pending ||
                {reqA_ready, reqB_ready} !== er) begin
                bad++;
                $display("[TB] FAIL cycle_outputs t=%0t got theme=%0d base=%b border=%h fa=%b pend=%b rdy=%b%b, expected theme=%0d base=%b fa=%b pend=%b rdy=%b",
                         $time, theme_idx, {base_R, base_G, base_B}, border_RGB, flash_active,
                         pending, reqA_ready, reqB_ready, m_theme, eb, (m_left > 0), m_pending, er);
            end
        end
    end

    task automatic tick();
        logic ax, bx;
        @(negedge clk);
        ax = reqA_valid && reqA_ready;
        bx = reqB_valid && reqB_ready;
        @(posedge clk);
        #1;
        if (ax) reqA_valid = 1'b0;
        if (bx) reqB_valid = 1'b0;
        startOfFrame = 1'b0;
        flash_req    = 1'b0;
    endtask

    task automatic applyStimulus(input logic sof, input logic fl);
        startOfFrame = sof;
        flash_req    = fl;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [1:0] th, input logic [7:0] base,
                               input logic [7:0] border, input logic fa, input logic pd);
        total++;
        if (theme_idx !== th || {base_R, base_G, base_B} !== base || border_RGB !== border ||
            flash_active !== fa || pending !== pd) begin
            bad++;
            $display("[TB] FAIL %s got theme=%0d base=%b border=%h fa=%b pend=%b, expected theme=%0d base=%b border=%h fa=%b pend=%b",
                     name, theme_idx, {base_R, base_G, base_B}, border_RGB, flash_active, pending,
                     th, base, border, fa, pd);
        end
    endtask

    task automatic checkReady(input string name, input logic [1:0] exp);
        #1;
        total++;
        if ({reqA_ready, reqB_ready} !== exp) begin
            bad++;
            $display("[TB] FAIL %s got ready=%b%b, expected %b", name, reqA_ready, reqB_ready, exp);
        end
    endtask

    task automatic waitDropA(input int budget);
        int n;
        n = 0;
        while (reqA_valid && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (reqA_valid) begin
            bad++;
            $display("[TB] FAIL waitDropA got valid still high after %0d cycles, expected a grant", budget);
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; flash_req = 1'b0;
        reqA_valid = 1'b1; reqA_theme = 2'd1; reqB_valid = 1'b1; reqB_theme = 2'd2;
        tick();
        tick();
        checkReady("ready_in_reset", 2'b00);
        checkOutput("reset_state", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b0);
        reqA_valid = 1'b0; reqB_valid = 1'b0;
        reset = 1'b0;
        tick();

        $display("[TB] single requester A, theme 1");
        reqA_valid = 1'b1; reqA_theme = 2'd1;
        checkReady("grant_A_single", 2'b10);
        tick();
        checkOutput("A_pending", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("A_commit", 2'd1, 8'b000_000_11, 8'hFF, 1'b0, 1'b0);

        $display("[TB] contention and round robin");
        pulseReset();
        reqA_valid = 1'b1; reqA_theme = 2'd2; reqB_valid = 1'b1; reqB_theme = 2'd3;
        checkReady("both_from_reset_A", 2'b10);
        tick();
        checkOutput("AB_pending", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b1);
        checkReady("hold_no_ready", 2'b00);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("AB_commit1", 2'd2, 8'b111_011_00, 8'hFC, 1'b0, 1'b0);
        reqA_valid = 1'b1; reqA_theme = 2'd1;
        checkReady("contest_B_wins", 2'b01);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("AB_commit2", 2'd3, 8'b011_011_01, 8'hFC, 1'b0, 1'b0);
        checkReady("waiting_A_now", 2'b10);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("A_after_B", 2'd1, 8'b000_000_11, 8'hFF, 1'b0, 1'b0);
        reqA_valid = 1'b1; reqA_theme = 2'd0; reqB_valid = 1'b1; reqB_theme = 2'd2;
        checkReady("repeat_B_wins", 2'b01);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("repeat_commit", 2'd2, 8'b111_011_00, 8'hFC, 1'b0, 1'b0);
        waitDropA(4);
        applyStimulus(1'b1, 1'b0);
        checkOutput("late_A_commit", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b0);

        $display("[TB] flash of %0d frames", FF);
        pulseReset();
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("flash_armed", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("flash_on", 2'd0, 8'b101_001_11, 8'hFC, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("flash_last_frame", 2'd0, 8'b101_001_11, 8'hFC, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("flash_off", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b0);

        $display("[TB] flash reload and commit during flash");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        reqA_valid = 1'b1; reqA_theme = 2'd3;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("commit_in_flash", 2'd3, 8'b100_100_10, 8'hFC, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("extended_on", 2'd3, 8'b100_100_10, 8'hFC, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("extended_off", 2'd3, 8'b011_011_01, 8'hFC, 1'b0, 1'b0);

        $display("[TB] reset during HOLD and flash");
        pulseReset();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        reqA_valid = 1'b1; reqA_theme = 2'd2;
        tick();
        checkOutput("before_reset", 2'd0, 8'b101_001_11, 8'hFC, 1'b1, 1'b1);
        pulseReset();
        checkOutput("reset_mid", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("no_commit_after_reset", 2'd0, 8'b010_110_00, 8'hFC, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout, expected stimulus to complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
